// File: rtl/rr_hold_arbiter_pkg.sv
// Shared types for the round-robin hold arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   ARB_N_DEFAULT  : default requester count
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    localparam int ARB_N_DEFAULT = 3;

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder.
//   elig   in  N   eligible requesters
//   ptr    in  PW  index of the highest-priority requester
//   onehot out N   one-hot of the chosen requester (zero when none)
//   idx    out PW  index of the chosen requester
//   valid  out 1   at least one requester is eligible
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int pos_s;

    // Scan from the farthest position back to ptr so the nearest eligible
    // requester (in rotating order) is the last one written and wins.
    always_comb begin
        idx   = {PW{1'b0}};
        valid = 1'b0;
        pos_s = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos_s = (int'(ptr) + k) % N;
            idx   = elig[pos_s] ? PW'(pos_s) : idx;
            valid = valid | elig[pos_s];
        end
    end

    assign onehot = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : {N{1'b0}};

endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered round-robin arbiter with grant hold and
// maximum tenure. A grant stays with its owner while the owner remains
// eligible (req & en), up to MAX_HOLD cycles, then ownership rotates.
// After each tenure GAP zero-grant cycles are inserted before the next grant.
//   clk           in   1  clock
//   rst           in   1  synchronous reset, active-low
//   req           in   N  request per requester
//   en            in   N  per-requester enable
//   grant         out  N  one-hot-or-zero grant, registered
//   busy          out  1  any grant bit set, registered
//   hold_expired  out  1  one-cycle pulse when a tenure is cut by MAX_HOLD
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] en,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         hold_expired
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [N-1:0]  grant_r;
    logic [N-1:0]  grant_nxt_s;
    logic          busy_r;
    logic          expired_r;
    logic          expired_nxt_s;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic [PW-1:0] owner_r;
    logic [PW-1:0] owner_nxt_s;
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_nxt_s;
    logic [1:0]    gap_cnt_r;
    logic [1:0]    gap_nxt_s;

    logic [N-1:0]  elig_s;
    logic [PW-1:0] ptr_rel_s;
    logic [PW-1:0] pick_ptr_s;
    logic [N-1:0]  pick_onehot_s;
    logic [PW-1:0] pick_idx_s;
    logic          pick_valid_s;
    logic          owner_hit_s;
    logic          hold_max_s;

    assign elig_s      = req & en;
    assign ptr_rel_s   = (owner_r == PW'(N - 1)) ? {PW{1'b0}} : owner_r + PW'(1);
    assign owner_hit_s = elig_s[owner_r];
    assign hold_max_s  = (hold_cnt_r == HW'(MAX_HOLD));
    // Re-arbitration out of GRANT (GAP == 0) must already use the rotated pointer.
    assign pick_ptr_s  = (state_r == ARB_GRANT) ? ptr_rel_s : ptr_r;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .elig   (elig_s),
        .ptr    (pick_ptr_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Next-state, next-grant and counter logic for the arbiter FSM.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        owner_nxt_s   = owner_r;
        ptr_nxt_s     = ptr_r;
        hold_nxt_s    = hold_cnt_r;
        gap_nxt_s     = gap_cnt_r;
        expired_nxt_s = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = ARB_GRANT;
                    grant_nxt_s = pick_onehot_s;
                    owner_nxt_s = pick_idx_s;
                    hold_nxt_s  = HW'(1);
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!owner_hit_s || hold_max_s) begin
                    grant_nxt_s   = {N{1'b0}};
                    ptr_nxt_s     = ptr_rel_s;
                    hold_nxt_s    = {HW{1'b0}};
                    expired_nxt_s = owner_hit_s && hold_max_s;
                    if (GAP > 0) begin
                        state_nxt_s = ARB_GAP;
                        gap_nxt_s   = 2'd1;
                    end else if (pick_valid_s) begin
                        // Back-to-back hand-over: new grant at the release edge.
                        state_nxt_s = ARB_GRANT;
                        grant_nxt_s = pick_onehot_s;
                        owner_nxt_s = pick_idx_s;
                        hold_nxt_s  = HW'(1);
                    end else begin
                        state_nxt_s = ARB_IDLE;
                    end
                end else begin
                    hold_nxt_s = hold_cnt_r + HW'(1);
                end
            end
            ARB_GAP: begin
                // The last gap cycle arbitrates at its closing edge, so exactly
                // GAP zero-grant cycles separate two tenures.
                if (gap_cnt_r == 2'(GAP)) begin
                    gap_nxt_s = 2'd0;
                    if (pick_valid_s) begin
                        state_nxt_s = ARB_GRANT;
                        grant_nxt_s = pick_onehot_s;
                        owner_nxt_s = pick_idx_s;
                        hold_nxt_s  = HW'(1);
                    end else begin
                        state_nxt_s = ARB_IDLE;
                    end
                end else begin
                    gap_nxt_s = gap_cnt_r + 2'd1;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                grant_nxt_s = {N{1'b0}};
                hold_nxt_s  = {HW{1'b0}};
                gap_nxt_s   = 2'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ARB_IDLE;
            grant_r    <= {N{1'b0}};
            busy_r     <= 1'b0;
            expired_r  <= 1'b0;
            ptr_r      <= {PW{1'b0}};
            owner_r    <= {PW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            gap_cnt_r  <= 2'd0;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            busy_r     <= |grant_nxt_s;
            expired_r  <= expired_nxt_s;
            ptr_r      <= ptr_nxt_s;
            owner_r    <= owner_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            gap_cnt_r  <= gap_nxt_s;
        end
    end

    assign grant        = grant_r;
    assign busy         = busy_r;
    assign hold_expired = expired_r;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter: instance a uses MAX_HOLD=8, GAP=1,
// instance b uses MAX_HOLD=8, GAP=0. Outputs are sampled 1 time unit after
// each rising edge; inputs change at the same point.
module tb_rr_hold_arbiter;

    logic       clk;
    logic       rst_a;
    logic [2:0] req_a;
    logic [2:0] en_a;
    logic [2:0] grant_a;
    logic       busy_a;
    logic       he_a;
    logic       rst_b;
    logic [2:0] req_b;
    logic [2:0] en_b;
    logic [2:0] grant_b;
    logic       busy_b;
    logic       he_b;

    int tests_run;
    int tests_failed;

    rr_hold_arbiter #(.N(3), .MAX_HOLD(8), .GAP(1)) dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .req          (req_a),
        .en           (en_a),
        .grant        (grant_a),
        .busy         (busy_a),
        .hold_expired (he_a)
    );

    rr_hold_arbiter #(.N(3), .MAX_HOLD(8), .GAP(0)) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .req          (req_b),
        .en           (en_b),
        .grant        (grant_b),
        .busy         (busy_b),
        .hold_expired (he_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_a(input string tag, input logic [2:0] g, input logic he);
        chk({tag, ".grant"}, 32'(grant_a), 32'(g));
        chk({tag, ".busy"}, 32'(busy_a), 32'(|g));
        chk({tag, ".hexp"}, 32'(he_a), 32'(he));
    endtask

    task automatic obs_b(input string tag, input logic [2:0] g, input logic he);
        chk({tag, ".grant"}, 32'(grant_b), 32'(g));
        chk({tag, ".busy"}, 32'(busy_b), 32'(|g));
        chk({tag, ".hexp"}, 32'(he_b), 32'(he));
    endtask

    // n cycles of a steady grant on instance a with no expiry pulse.
    task automatic run_a(input string tag, input logic [2:0] g, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            obs_a(tag, g, 1'b0);
        end
    endtask

    task automatic run_b(input string tag, input logic [2:0] g, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            obs_b(tag, g, 1'b0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_a = 1'b0;
        req_a = 3'b111;
        en_a  = 3'b111;
        rst_b = 1'b0;
        req_b = 3'b101;
        en_b  = 3'b111;

        // Reset held with all requesters active.
        step();
        obs_a("rst0", 3'b000, 1'b0);
        step();
        obs_a("rst1", 3'b000, 1'b0);
        rst_a = 1'b1;
        step();
        obs_a("rst_rel", 3'b001, 1'b0);

        // Full rotation, each tenure cut at 8 cycles, one gap cycle between.
        run_a("rot0", 3'b001, 7);
        step();
        obs_a("rot0_end", 3'b000, 1'b1);
        run_a("rot1", 3'b010, 8);
        step();
        obs_a("rot1_end", 3'b000, 1'b1);
        run_a("rot2", 3'b100, 8);
        step();
        obs_a("rot2_end", 3'b000, 1'b1);
        run_a("rot3", 3'b001, 1);

        // Early release by req drop: no expiry pulse, next in line is 2.
        req_a = 3'b101;
        run_a("early", 3'b001, 2);
        req_a = 3'b100;
        step();
        obs_a("early_rel", 3'b000, 1'b0);
        run_a("early_next", 3'b100, 1);

        // Enable mask: requester 0 requests but is disabled.
        req_a = 3'b011;
        en_a  = 3'b010;
        step();
        obs_a("mask_rel", 3'b000, 1'b0);
        run_a("mask", 3'b010, 2);
        en_a = 3'b000;
        step();
        obs_a("en_drop", 3'b000, 1'b0);
        run_a("idle", 3'b000, 2);

        // Reset in the middle of a tenure (hold_cnt == 4); ptr must return to 0.
        req_a = 3'b111;
        en_a  = 3'b111;
        run_a("mid", 3'b100, 4);
        rst_a = 1'b0;
        step();
        obs_a("mid_rst", 3'b000, 1'b0);
        rst_a = 1'b1;
        step();
        obs_a("mid_ptr0", 3'b001, 1'b0);

        // GAP = 0: hand-over without a zero cycle.
        step();
        obs_b("g0_rst", 3'b000, 1'b0);
        rst_b = 1'b1;
        run_b("g0_t0", 3'b001, 8);
        step();
        obs_b("g0_hand", 3'b100, 1'b1);
        run_b("g0_t1", 3'b100, 1);
        req_b = 3'b001;
        step();
        obs_b("g0_early", 3'b001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
